// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX packet FIFO: bus widths, write-FSM
// states and the beat layout held in storage.
package eth_pkg;

    localparam int ETH_DATA_W = 64;
    localparam int ETH_KEEP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic [ETH_DATA_W-1:0] tdata;
        logic [ETH_KEEP_W-1:0] tkeep;
        logic                  tlast;
    } eth_beat_t;

endpackage

// File: rtl/eth_tx_pkt_fifo_ram.sv
// Simple dual-port beat storage: one write port, registered read port
// (data appears the cycle after rd_en and holds while rd_en is low).
module eth_tx_pkt_fifo_ram
    import eth_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          refclk_p,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  eth_beat_t     wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output eth_beat_t     rd_data
);

    eth_beat_t mem [DEPTH];

    always_ff @(posedge refclk_p) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/eth_tx_pkt_fifo.sv
// Store-and-forward TX frame FIFO in front of the 10G MAC. Define
// ETH_TX_PKT_FIFO_STATS_EN to add the stat_tx_frames / stat_drops counters.
module eth_tx_pkt_fifo
    import eth_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                  refclk_p,
    input  logic                  reset,
    input  logic [ETH_DATA_W-1:0] s_axis_tdata,
    input  logic [ETH_KEEP_W-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [ETH_DATA_W-1:0] m_axis_tx_tdata,
    output logic [ETH_KEEP_W-1:0] m_axis_tx_tkeep,
    output logic                  m_axis_tx_tlast,
    output logic                  m_axis_tx_tuser,
    output logic                  m_axis_tx_tvalid,
    input  logic                  m_axis_tx_tready,
`ifdef ETH_TX_PKT_FIFO_STATS_EN
    output logic [31:0]           stat_tx_frames,
    output logic [15:0]           stat_drops,
`endif
    output logic                  drop_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE     = PW'(1);

    // Both streams use valid/ready: a beat moves on the rising edge where
    // valid and ready are both high; a held beat never changes until it moves.
    wr_state_e       wr_state, wr_state_nxt;
    logic [PW-1:0]   wr_ptr, wr_ptr_nxt, com_ptr, com_ptr_nxt;
    logic [PW-1:0]   rd_ptr, fetch_ptr, frame_cnt;
    logic            accept, full, ram_wr, commit, drop_evt;
    logic            s1_valid, out_valid, move, fetch, out_hs, out_last_hs;
    eth_beat_t       wr_beat, ram_rd, out_beat;

    assign s_axis_tready = ~reset;
    assign accept        = s_axis_tvalid & s_axis_tready;
    // rd_ptr only moves on output handshakes, so prefetched beats still count.
    assign full          = (wr_ptr - rd_ptr) == DEPTH_P;
    assign wr_beat       = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};

    always_ff @(posedge refclk_p) begin
        if (reset) wr_state <= ST_IDLE;
        else       wr_state <= wr_state_nxt;
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_ptr_nxt   = wr_ptr;
        com_ptr_nxt  = com_ptr;
        ram_wr       = 1'b0;
        commit       = 1'b0;
        drop_evt     = 1'b0;
        if (accept) begin
            case (wr_state)
                ST_DROP: begin
                    if (s_axis_tlast) begin
                        wr_state_nxt = ST_IDLE;
                        wr_ptr_nxt   = com_ptr;
                        drop_evt     = 1'b1;
                    end
                end
                default: begin
                    if (full || (s_axis_tlast && s_axis_tuser)) begin
                        wr_ptr_nxt = com_ptr;
                        if (s_axis_tlast) begin
                            wr_state_nxt = ST_IDLE;
                            drop_evt     = 1'b1;
                        end else begin
                            wr_state_nxt = ST_DROP;
                        end
                    end else begin
                        ram_wr     = 1'b1;
                        wr_ptr_nxt = wr_ptr + ONE;
                        if (s_axis_tlast) begin
                            wr_state_nxt = ST_IDLE;
                            com_ptr_nxt  = wr_ptr + ONE;
                            commit       = 1'b1;
                        end else begin
                            wr_state_nxt = ST_WRITE;
                        end
                    end
                end
            endcase
        end
    end

    // Two-stage read pipe: RAM output (s1) feeds the output register. The RAM
    // holds its output when no fetch is issued, so s1 needs no extra storage.
    assign out_hs      = out_valid & m_axis_tx_tready;
    assign out_last_hs = out_hs & out_beat.tlast;
    assign move        = s1_valid & (~out_valid | m_axis_tx_tready);
    assign fetch       = (fetch_ptr != com_ptr) & (~s1_valid | move);

    eth_tx_pkt_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .refclk_p (refclk_p),
        .wr_en    (ram_wr),
        .wr_addr  (wr_ptr[AW-1:0]),
        .wr_data  (wr_beat),
        .rd_en    (fetch),
        .rd_addr  (fetch_ptr[AW-1:0]),
        .rd_data  (ram_rd)
    );

    always_ff @(posedge refclk_p) begin
        if (reset) begin
            wr_ptr     <= '0;
            com_ptr    <= '0;
            rd_ptr     <= '0;
            fetch_ptr  <= '0;
            frame_cnt  <= '0;
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_beat   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            com_ptr    <= com_ptr_nxt;
            drop_pulse <= drop_evt;
            if (fetch)  fetch_ptr <= fetch_ptr + ONE;
            if (out_hs) rd_ptr    <= rd_ptr + ONE;
            if (fetch)     s1_valid <= 1'b1;
            else if (move) s1_valid <= 1'b0;
            if (move) begin
                out_valid <= 1'b1;
                out_beat  <= ram_rd;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            case ({commit, out_last_hs})
                2'b10:   frame_cnt <= frame_cnt + ONE;
                2'b01:   frame_cnt <= frame_cnt - ONE;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

    assign m_axis_tx_tdata  = out_beat.tdata;
    assign m_axis_tx_tkeep  = out_beat.tkeep;
    assign m_axis_tx_tlast  = out_beat.tlast;
    assign m_axis_tx_tuser  = 1'b0;
    assign m_axis_tx_tvalid = out_valid;

`ifdef ETH_TX_PKT_FIFO_STATS_EN
    always_ff @(posedge refclk_p) begin
        if (reset) begin
            stat_tx_frames <= '0;
            stat_drops     <= '0;
        end else begin
            if (out_last_hs) stat_tx_frames <= stat_tx_frames + 32'd1;
            if (drop_pulse && stat_drops != 16'hFFFF) stat_drops <= stat_drops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_pkt_fifo.sv
// Directed and constrained-random bench for eth_tx_pkt_fifo at DEPTH=16;
// stats checks are compiled in when ETH_TX_PKT_FIFO_STATS_EN is defined.
module tb_eth_tx_pkt_fifo;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast, s_tuser, s_tvalid, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast, m_tuser, m_tvalid, m_ready;
    logic        drop_pulse;
`ifdef ETH_TX_PKT_FIFO_STATS_EN
    logic [31:0] stat_tx_frames;
    logic [15:0] stat_drops;
`endif

    eth_tx_pkt_fifo #(.DEPTH(DEPTH)) dut (
        .refclk_p         (clk),
        .reset            (reset),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tlast     (s_tlast),
        .s_axis_tuser     (s_tuser),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .m_axis_tx_tdata  (m_tdata),
        .m_axis_tx_tkeep  (m_tkeep),
        .m_axis_tx_tlast  (m_tlast),
        .m_axis_tx_tuser  (m_tuser),
        .m_axis_tx_tvalid (m_tvalid),
        .m_axis_tx_tready (m_ready),
`ifdef ETH_TX_PKT_FIFO_STATS_EN
        .stat_tx_frames   (stat_tx_frames),
        .stat_drops       (stat_drops),
`endif
        .drop_pulse       (drop_pulse)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_bad = 0;
    int out_beats = 0;
    int n_pushed = 0;
    int n_drops = 0;
    logic mon_en = 1'b1;
    logic rnd_mode = 1'b0;
    logic [72:0] exp_q[$];

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard / monitor, sampled on the falling edge
    logic        prev_stall = 1'b0;
    logic [72:0] prev_beat;
    always @(negedge clk) begin
        if (drop_pulse) n_drops++;
        if (mon_en) begin
            if (prev_stall)
                chk("stall_hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, prev_beat});
            if (m_tvalid && m_ready) begin
                out_beats++;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", out_beats, n_pushed);
                end else begin
                    logic [72:0] e;
                    e = exp_q.pop_front();
                    chk("beat", {m_tuser, m_tlast, m_tkeep, m_tdata}, {1'b0, e});
                end
            end
            prev_stall = m_tvalid && !m_ready;
            prev_beat  = {m_tlast, m_tkeep, m_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // driver tasks; all are entered and left 1 time unit after a rising edge
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                              input logic u, input logic keep_it);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        if (keep_it) begin
            exp_q.push_back({l, k, d});
            n_pushed++;
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic abort, input logic keep_it);
        for (int i = 0; i < len; i++) begin
            logic last;
            last = (i == len - 1);
            drive_beat({$urandom, $urandom}, last ? 8'($urandom_range(1, 255)) : 8'hFF,
                       last, abort && last, keep_it);
        end
    endtask

    task automatic wait_drain(input int budget);
        int w = 0;
        while (exp_q.size() != 0 && w < budget) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_room(input int len);
        int w = 0;
        while (exp_q.size() + len > DEPTH && w < 5000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("room", (exp_q.size() + len <= DEPTH), 1);
    endtask

    initial begin
        int b0, d0, exp_drops;
        reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
        s_tlast = 1'b0; s_tuser = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_frame_cnt", dut.frame_cnt, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("s_tready_run", s_tready, 1);

        // 3-beat frame and first-beat latency
        m_ready = 1'b1;
        b0 = out_beats;
        drive_beat(64'h0123456789abcdef, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive_beat(64'hfedcba9876543210, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive_beat(64'h00000000deadbeef, 8'h0F, 1'b1, 1'b0, 1'b1);
        chk("lat_c0", m_tvalid, 0);
        @(posedge clk); #1;
        chk("lat_c1", m_tvalid, 0);
        @(posedge clk); #1;
        chk("lat_c2", m_tvalid, 1);
        wait_drain(100);
        chk("t1_beats", out_beats - b0, 3);
`ifdef ETH_TX_PKT_FIFO_STATS_EN
        chk("stat_tx_frames", stat_tx_frames, 1);
`endif

        // aborted frame followed by a good one
        d0 = n_drops;
        send_frame(4, 1'b1, 1'b0);
        send_frame(2, 1'b0, 1'b1);
        wait_drain(100);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_drops", n_drops - d0, 1);
`ifdef ETH_TX_PKT_FIFO_STATS_EN
        chk("stat_drops", stat_drops, 1);
`endif

        // exactly DEPTH beats fit; next frame overflows while output stalled
        m_ready = 1'b0;
        b0 = out_beats;
        d0 = n_drops;
        send_frame(DEPTH, 1'b0, 1'b1);
        send_frame(2, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_drops", n_drops - d0, 1);
        chk("t3_valid_stalled", m_tvalid, 1);
        m_ready = 1'b1;
        wait_drain(200);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_beats", out_beats - b0, DEPTH);

        // DEPTH+1 beats into an empty FIFO is dropped
        b0 = out_beats;
        d0 = n_drops;
        send_frame(DEPTH + 1, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t3b_drops", n_drops - d0, 1);
        chk("t3b_beats", out_beats - b0, 0);

        // reset in the middle of a readout
        mon_en = 1'b0;
        send_frame(10, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_rst_ready", s_tready, 0);
        chk("t4_valid", m_tvalid, 0);
        chk("t4_frame_cnt", dut.frame_cnt, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_no_stale", m_tvalid, 0);
        mon_en = 1'b1;
        send_frame(5, 1'b0, 1'b1);
        wait_drain(100);

        // back-to-back single-beat frames
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_beat({$urandom, $urandom}, 8'($urandom_range(1, 255)), 1'b1, 1'b0, 1'b1);
            end
            begin
                int w = 0;
                while (!m_tvalid && w < 20) begin
                    @(posedge clk); #1;
                    w++;
                end
                chk("t5_first_lat", w, 3);
                for (int i = 0; i < 8; i++) begin
                    chk("t5_valid", m_tvalid, 1);
                    chk("t5_tlast", m_tlast, 1);
                    @(posedge clk); #1;
                end
                chk("t5_end", m_tvalid, 0);
            end
        join
        wait_drain(50);

        // random output backpressure, mixed frame sizes and aborts
        d0 = n_drops;
        exp_drops = 0;
        rnd_mode = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int len;
            logic abort;
            len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 40))
                                                : int'($urandom_range(1, 16));
            abort = ($urandom_range(0, 7) == 0);
            if (!abort && len <= DEPTH) begin
                wait_room(len);
                send_frame(len, 1'b0, 1'b1);
            end else begin
                send_frame(len, abort, 1'b0);
                exp_drops++;
            end
        end
        rnd_mode = 1'b0;
        m_ready = 1'b1;
        wait_drain(2000);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_drops", n_drops - d0, exp_drops);
        chk("t6_idle", m_tvalid, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
